// File: rtl/audio_mix_pkg.sv
// Shared constants, register map, FSM states and the 16-bit saturator for the N-channel audio mixer.
package audio_mix_pkg;
    localparam int AUDIO_W = 16;

    localparam logic [4:0] VOL_BASE = 5'h00;
    localparam logic [4:0] MASTER   = 5'h10;
    localparam logic [4:0] MUTE     = 5'h11;
    localparam logic [4:0] STATUS   = 5'h12;

    typedef enum logic [2:0] {ST_IDLE, ST_SNAP, ST_MAC, ST_MST, ST_SAT} mix_state_t;

    function automatic logic [AUDIO_W-1:0] sat16(input logic signed [31:0] v);
        if (v > 32'sd32767) return 16'h7fff;
        if (v < -32'sd32768) return 16'h8000;
        return v[AUDIO_W-1:0];
    endfunction
endpackage

// File: rtl/audio_mix_lane.sv
// One output side of the mixer: sample snapshot, time-shared channel MAC, master scale and saturation.
module audio_mix_lane
    import audio_mix_pkg::*;
#(
    parameter int CH    = 4,
    parameter int VOL_W = 8,
    parameter int IDX_W = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    snap,
    input  logic                    mac,
    input  logic                    mst,
    input  logic                    sat,
    input  logic [CH*AUDIO_W-1:0]   in_bus,
    input  logic [IDX_W-1:0]        idx,
    input  logic [VOL_W:0]          gain,
    input  logic [VOL_W:0]          master,
    output logic [AUDIO_W-1:0]      snd,
    output logic                    clip
);
    localparam int ACC_W = AUDIO_W + $clog2(CH) + 2;
    localparam int PRD_W = AUDIO_W + VOL_W + 2;
    localparam int MPR_W = ACC_W + VOL_W + 2;

    logic [CH*AUDIO_W-1:0]     smp;
    logic signed [ACC_W-1:0]   acc;
    logic signed [AUDIO_W-1:0] cur;
    logic signed [PRD_W-1:0]   prd;
    logic signed [MPR_W-1:0]   mprd;
    logic signed [31:0]        acc_x;

    // Gains are unsigned; the zero MSB keeps them positive in the signed multiply.
    assign cur   = smp[idx*AUDIO_W +: AUDIO_W];
    assign prd   = cur * $signed({1'b0, gain});
    assign mprd  = acc * $signed({1'b0, master});
    assign acc_x = 32'(acc);
    assign clip  = sat && ((acc_x > 32'sd32767) || (acc_x < -32'sd32768));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            smp <= '0;
            acc <= '0;
            snd <= '0;
        end else begin
            if (snap) begin
                smp <= in_bus;
                acc <= '0;
            end
            if (mac) acc <= acc + ACC_W'(prd >>> VOL_W);
            if (mst) acc <= ACC_W'(mprd >>> VOL_W);
            if (sat) snd <= sat16(acc_x);
        end
    end
endmodule

// File: rtl/audio_mix_nch.sv
// N-channel stereo mixer top: CPU registers, per-pass gain snapshot, FSM and channel index.
// Define AUDIO_MIX_RAMP_EN to ramp channel gains toward their targets by RAMP_STEP per pass.
module audio_mix_nch
    import audio_mix_pkg::*;
#(
    parameter int CH        = 4,
    parameter int VOL_W     = 8,
    parameter int RAMP_STEP = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               next_sample,
    input  logic [CH*16-1:0]   in_l,
    input  logic [CH*16-1:0]   in_r,
    input  logic               cfg_we,
    input  logic [4:0]         cfg_addr,
    input  logic [15:0]        cfg_dat,
    output logic [15:0]        cfg_rdat,
    output logic [15:0]        snd_l,
    output logic [15:0]        snd_r,
    output logic               out_valid,
    output logic               busy
);
    localparam int IDX_W = (CH > 1) ? $clog2(CH) : 1;
    localparam logic [VOL_W:0] UNITY = {1'b1, {VOL_W{1'b0}}};

    logic [VOL_W:0]   vol    [CH];
    logic [VOL_W:0]   g_eff  [CH];
    logic [VOL_W:0]   g_snap [CH];
    logic [VOL_W:0]   master;
    logic [VOL_W:0]   wr_vol;
    logic [CH-1:0]    mute;
    logic             clip_st, ovr_st, wr_stat;
    logic [IDX_W-1:0] idx;
    mix_state_t       state, state_nxt;

    logic [1:0][CH*AUDIO_W-1:0] in_bus;
    logic [1:0][AUDIO_W-1:0]    snd;
    logic [1:0]                 clip;

    assign wr_vol  = (cfg_dat > 16'(UNITY)) ? UNITY : cfg_dat[VOL_W:0];
    assign wr_stat = cfg_we && (cfg_addr == STATUS);
    assign busy    = (state != ST_IDLE);

`ifdef AUDIO_MIX_RAMP_EN
    logic [VOL_W:0] g_cur [CH];

    function automatic logic [VOL_W:0] ramp(input logic [VOL_W:0] c, input logic [VOL_W:0] t);
        logic [VOL_W+1:0] up, dn;
        up = {1'b0, c} + (VOL_W+2)'(RAMP_STEP);
        dn = {1'b0, c} - (VOL_W+2)'(RAMP_STEP);
        if (c < t) return (up > {1'b0, t}) ? t : up[VOL_W:0];
        if (c > t) return (dn[VOL_W+1] || (dn < {1'b0, t})) ? t : dn[VOL_W:0];
        return c;
    endfunction

    always_comb for (int i = 0; i < CH; i++) g_eff[i] = ramp(g_cur[i], vol[i]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) for (int i = 0; i < CH; i++) g_cur[i] <= '0;
        else if (state == ST_SNAP) for (int i = 0; i < CH; i++) g_cur[i] <= g_eff[i];
    end
`else
    always_comb for (int i = 0; i < CH; i++) g_eff[i] = vol[i];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CH; i++) vol[i] <= '0;
            master <= UNITY;
            mute   <= '0;
        end else if (cfg_we) begin
            for (int i = 0; i < CH; i++)
                if (cfg_addr == VOL_BASE + 5'(i)) vol[i] <= wr_vol;
            if (cfg_addr == MASTER) master <= wr_vol;
            if (cfg_addr == MUTE)   mute   <= cfg_dat[CH-1:0];
        end
    end

    always_comb begin
        cfg_rdat = '0;
        for (int i = 0; i < CH; i++)
            if (cfg_addr == VOL_BASE + 5'(i)) cfg_rdat[VOL_W:0] = vol[i];
        if (cfg_addr == MASTER) cfg_rdat[VOL_W:0] = master;
        if (cfg_addr == MUTE)   cfg_rdat[CH-1:0]  = mute;
        if (cfg_addr == STATUS) cfg_rdat[1:0]     = {clip_st, ovr_st};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (next_sample) state_nxt = ST_SNAP;
            ST_SNAP: state_nxt = ST_MAC;
            ST_MAC:  if (idx == IDX_W'(CH-1)) state_nxt = ST_MST;
            ST_MST:  state_nxt = ST_SAT;
            ST_SAT:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Mute is folded into the snapped gain, so register writes mid-pass cannot disturb it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            idx       <= '0;
            out_valid <= 1'b0;
            clip_st   <= 1'b0;
            ovr_st    <= 1'b0;
            for (int i = 0; i < CH; i++) g_snap[i] <= '0;
        end else begin
            state     <= state_nxt;
            idx       <= (state == ST_MAC) ? idx + 1'b1 : '0;
            out_valid <= (state == ST_SAT);
            clip_st   <= ((state == ST_SAT) && |clip) | (clip_st & ~(wr_stat & cfg_dat[1]));
            ovr_st    <= (busy && next_sample) | (ovr_st & ~(wr_stat & cfg_dat[0]));
            if (state == ST_SNAP)
                for (int i = 0; i < CH; i++) g_snap[i] <= mute[i] ? '0 : g_eff[i];
        end
    end

    assign in_bus = {in_r, in_l};

    for (genvar s = 0; s < 2; s++) begin : g_lane
        audio_mix_lane #(.CH(CH), .VOL_W(VOL_W), .IDX_W(IDX_W)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .snap   (state == ST_SNAP),
            .mac    (state == ST_MAC),
            .mst    (state == ST_MST),
            .sat    (state == ST_SAT),
            .in_bus (in_bus[s]),
            .idx    (idx),
            .gain   (g_snap[idx]),
            .master (master),
            .snd    (snd[s]),
            .clip   (clip[s])
        );
    end

    assign snd_l = snd[0];
    assign snd_r = snd[1];
endmodule
